expr_sweep_ctrl: RTL and testbench
==================================

Name: expr_sweep_ctrl

Overview:
- Sequential controller that drives an exhaustive truth-table sweep into a pair of combinational expression blocks: a reference gate-level form and its NAND-only equivalent.
- On a start pulse it steps the shared input vector through every code and waits a programmable settle time at each one.
- At each code it samples both outputs, records the reference truth table, and counts mismatches.
- Sits beside the expression modules as the self-checking sequencer, replacing hand-written loop benches.

Parameters:
- N_IN, 3, number of expression inputs; vector width; sweep covers 2^N_IN codes.
- SETTLE, 1, extra wait cycles after each vector change before sampling (0 allowed).

Ports:
- clk  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  terminates the sweep in progress; ignored in IDLE/DONE.
- f_ref  input  1  output of reference expression block.
- f_nand  input  1  output of NAND-only expression block.
- vec  output  N_IN  input vector driven to both blocks ({a,b,c} for N_IN=3, MSB = a).
- busy  output  1  high from the cycle after start is accepted until DONE is entered.
- done  output  1  one-cycle pulse; sweep completed or aborted.
- aborted  output  1  sticky; set if the last sweep ended by abort.
- truth_tbl  output  2^N_IN  bit i = f_ref sampled at vec=i.
- err_cnt  output  N_IN+1  number of codes where f_ref != f_nand.
- fail_seen  output  1  at least one mismatch in the last sweep.
- first_fail  output  N_IN  lowest vec code that mismatched; valid only when fail_seen=1.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - vec=0, busy=0, done=0, aborted=0.
  - truth_tbl=0, err_cnt=0, fail_seen=0, first_fail=0.
  - Settle counter = 0.
- Reset asserted mid-sweep discards all partial results immediately. Exit from reset is synchronous to the next clk edge.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1 at an edge:
  - Clear truth_tbl, err_cnt, fail_seen, first_fail, aborted.
  - vec<=0, settle counter<=SETTLE, busy<=1.
  - Go to WAIT.
- WAIT: counter decrements each edge. When counter==0 at an edge, go to SAMPLE.
  - With SETTLE=0, WAIT lasts exactly one cycle.
- SAMPLE, single cycle, at its edge:
  - truth_tbl[vec]<=f_ref.
  - If f_ref!=f_nand: err_cnt+=1. If fail_seen was 0, set fail_seen<=1 and first_fail<=vec.
  - If vec==2^N_IN-1, go to DONE.
  - Otherwise vec<=vec+1, counter<=SETTLE, go to WAIT.
- vec changes only on the SAMPLE->WAIT edge, so each code is held stable for SETTLE+2 cycles.
- DONE, single cycle: done=1, busy=0, vec held at last value. Go to IDLE.
- All results hold until the next accepted start.
- Latency: done asserts 2^N_IN*(SETTLE+2)+1 cycles after the start edge. This is 25 cycles for defaults (N_IN=3, SETTLE=1).
- abort=1 in WAIT or SAMPLE:
  - Go to DONE at that edge and set aborted<=1.
  - A SAMPLE edge coinciding with abort does not record that sample.
  - Partial results are retained.
- Start while busy or in DONE is ignored. Start and abort together in IDLE: start wins, abort ignored.
- err_cnt width N_IN+1 holds the maximum 2^N_IN without wrap. vec does not wrap past the last code.
- f_ref and f_nand are assumed combinational from vec. No internal synchronisers.

Test Plan:
- Defaults, blocks implementing f=~(~a+(b&c)), start pulse:
  - truth_tbl=8'h70, err_cnt=0, fail_seen=0.
  - done pulses exactly 25 cycles after the start edge, aborted=0.
- Same setup, f_nand forced inverted only at vec=5:
  - err_cnt=1, fail_seen=1, first_fail=3'd5, truth_tbl=8'h70.
- f_nand tied to 0, f_ref correct:
  - err_cnt=3, first_fail=3'd4.
- SETTLE=0:
  - Each vec held 2 cycles; done at cycle 17.
- Start pulsed again at cycles 3 and 10 during a sweep:
  - Ignored; single done at cycle 25, results identical to the first scenario.
- Abort during WAIT with vec=3:
  - done next cycle, aborted=1, truth_tbl bits 0..2 valid, busy=0.
- rst_n low mid-sweep:
  - All outputs 0 immediately.
  - After release, start runs a clean full sweep.

Source files
------------

// File: rtl/expr_sweep_ctrl.sv
// expr_sweep_ctrl: steps a shared input vector through every code, samples a reference
// and a NAND-only expression output at each code, and records the truth table and mismatches.
`default_nettype none

module expr_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_ref,
  input  logic                 f_nand,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [2**N_IN-1:0]   truth_tbl,
  output logic [N_IN:0]        err_cnt,
  output logic                 fail_seen,
  output logic [N_IN-1:0]      first_fail
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      truth_tbl  <= '0;
      err_cnt    <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start beats a simultaneous abort here since abort is not looked at in IDLE
          if (start) begin
            truth_tbl  <= '0;
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
            aborted    <= 1'b0;
            vec        <= '0;
            cnt        <= SETTLE_LD;
            busy       <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else if (cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            truth_tbl[vec] <= f_ref;
            if (f_ref != f_nand) begin
              err_cnt <= err_cnt + (N_IN+1)'(1);
              if (!fail_seen) begin
                fail_seen  <= 1'b1;
                first_fail <= vec;
              end
            end
            if (vec == LAST_CODE) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              vec   <= vec + N_IN'(1);
              cnt   <= SETTLE_LD;
              state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_expr_sweep_ctrl.sv
// tb_expr_sweep_ctrl: directed sweeps of expr_sweep_ctrl (SETTLE=1 and SETTLE=0 instances)
// with a result scoreboard filled at start and drained when done pulses.
`default_nettype none

module tb_expr_sweep_ctrl;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] err;
    logic       fs;
    logic [2:0] ff;
    logic       ab;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  int   mode = 0;
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [2:0] vec0, vec1, ff0, ff1;
  logic [7:0] tt0, tt1;
  logic [3:0] err0, err1;
  logic busy0, busy1, done0, done1, ab0, ab1, fs0, fs1;
  logic fref0, fnand0, fref1, fnand1;

  always #5 clk = ~clk;

  // reference form and NAND-only form of f = ~(~a + (b&c))
  function automatic logic ref_f(input logic [2:0] v);
    return ~(~v[2] | (v[1] & v[0]));
  endfunction
  function automatic logic nand_f(input logic [2:0] v);
    logic n_bc, n_t;
    n_bc = ~(v[1] & v[0]);
    n_t  = ~(v[2] & n_bc);
    return ~(n_t & n_t);
  endfunction
  function automatic logic faulty_nand(input int m, input logic [2:0] v);
    if (m == 1) return nand_f(v) ^ (v == 3'd5);
    if (m == 2) return 1'b0;
    return nand_f(v);
  endfunction

  assign fref0  = ref_f(vec0);
  assign fnand0 = faulty_nand(mode, vec0);
  assign fref1  = ref_f(vec1);
  assign fnand1 = nand_f(vec1);

  expr_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .f_ref(fref0), .f_nand(fnand0), .vec(vec0), .busy(busy0), .done(done0),
    .aborted(ab0), .truth_tbl(tt0), .err_cnt(err0), .fail_seen(fs0), .first_fail(ff0));

  expr_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .f_ref(fref1), .f_nand(fnand1), .vec(vec1), .busy(busy1), .done(done1),
    .aborted(ab1), .truth_tbl(tt1), .err_cnt(err1), .fail_seen(fs1), .first_fail(ff1));

  logic [2:0] m_vec, m_ff;
  logic [7:0] m_tt;
  logic [3:0] m_err;
  logic m_busy, m_done, m_ab, m_fs;
  assign m_vec  = (sel == 1) ? vec1  : vec0;
  assign m_ff   = (sel == 1) ? ff1   : ff0;
  assign m_tt   = (sel == 1) ? tt1   : tt0;
  assign m_err  = (sel == 1) ? err1  : err0;
  assign m_busy = (sel == 1) ? busy1 : busy0;
  assign m_done = (sel == 1) ? done1 : done0;
  assign m_ab   = (sel == 1) ? ab1   : ab0;
  assign m_fs   = (sel == 1) ? fs1   : fs0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int m, input int settle, input int abort_code);
    exp_t e;
    e.tt = '0; e.err = '0; e.fs = 1'b0; e.ff = '0; e.ab = (abort_code >= 0);
    for (int c = 0; c < 8; c++) begin
      logic [2:0] v;
      v = 3'(c);
      if (abort_code >= 0 && c >= abort_code) break;
      e.tt[c] = ref_f(v);
      if (ref_f(v) != faulty_nand(m, v)) begin
        e.err = e.err + 4'd1;
        if (!e.fs) begin e.fs = 1'b1; e.ff = v; end
      end
    end
    // abort is raised in the first WAIT cycle of abort_code; DONE is entered at the next edge
    e.lat = (abort_code >= 0) ? abort_code * (settle + 2) + 2 : 8 * (settle + 2) + 1;
    sb.push_back(e);
  endtask

  // Cycle 1 is the clock period that begins at the start edge; done is observed in cycle lat.
  task automatic run(input int s, input int m, input int settle, input int abort_code, input bit ghost);
    exp_t e;
    int cyc, hold, extra;
    bit aborted_sent;
    logic [2:0] last_vec;
    sel = s; mode = m; aborted_sent = 1'b0;
    push_exp(m, settle, abort_code);
    if (s == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1; hold = 1; last_vec = m_vec;
    chk("busy_after_start", 32'(m_busy), 32'd1);
    while (!m_done && cyc < 200) begin
      if (abort_code >= 0 && !aborted_sent && m_vec == 3'(abort_code)) begin
        abort0 = 1'b1; aborted_sent = 1'b1;
      end
      if (ghost && s == 0) start0 = (cyc == 3 || cyc == 10);
      @(posedge clk); #1;
      abort0 = 1'b0; start0 = 1'b0;
      cyc++;
      if (m_vec != last_vec) begin
        chk("vec_hold", 32'(hold), 32'(settle + 2));
        chk("vec_step", 32'(m_vec), 32'(last_vec) + 32'd1);
        hold = 1; last_vec = m_vec;
      end else begin
        hold++;
      end
    end
    if (!m_done) begin
      chk("done_timeout", 32'(m_done), 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("truth_tbl", 32'(m_tt), 32'(e.tt));
    chk("err_cnt", 32'(m_err), 32'(e.err));
    chk("fail_seen", 32'(m_fs), 32'(e.fs));
    if (e.fs) chk("first_fail", 32'(m_ff), 32'(e.ff));
    chk("aborted", 32'(m_ab), 32'(e.ab));
    chk("busy_in_done", 32'(m_busy), 32'd0);
    if (abort_code >= 0) chk("vec_held_abort", 32'(m_vec), 32'(abort_code));
    else chk("vec_held_last", 32'(m_vec), 32'd7);
    @(posedge clk); #1;
    chk("done_pulse_width", 32'(m_done), 32'd0);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (m_done) extra++;
    end
    chk("no_extra_done", 32'(extra), 32'd0);
    chk("truth_tbl_holds", 32'(m_tt), 32'(e.tt));
    chk("err_cnt_holds", 32'(m_err), 32'(e.err));
  endtask

  initial begin
    #1;
    sel = 0;
    chk("rst_vec", 32'(m_vec), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_tt", 32'(m_tt), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_fs_ab_ff", {28'd0, m_fs, m_ab, m_ff[1:0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 0, 1, -1, 1'b0);
    run(0, 1, 1, -1, 1'b0);
    run(0, 2, 1, -1, 1'b0);
    run(1, 0, 0, -1, 1'b0);
    run(0, 0, 1, -1, 1'b1);
    run(0, 2, 1, 3, 1'b0);

    // reset in the middle of a sweep that has already logged results
    sel = 0; mode = 2;
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_reset_err", 32'(m_err), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vec", 32'(m_vec), 32'd0);
    chk("midrst_busy", 32'(m_busy), 32'd0);
    chk("midrst_tt", 32'(m_tt), 32'd0);
    chk("midrst_err", 32'(m_err), 32'd0);
    chk("midrst_fs", 32'(m_fs), 32'd0);
    chk("midrst_ff", 32'(m_ff), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 0, 1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
